ahb2ocp_ram_ctrl: RTL and testbench

Sequencing controller and two-port arbiter in front of the single-port ahb2ocp_ram buffer. After reset it zero-fills the whole array. It then shares the RAM between two requesters (port 0: AHB side, port 1: OCP side) using a req/gnt handshake with fair round-robin. It returns read data with a fixed one-cycle latency and flags out-of-range accesses instead of issuing them.

---
 rtl/ahb2ocp_ram_ctrl_pkg.sv | 13 +
 rtl/ahb2ocp_ram_rr_arb.sv | 50 +++++
 rtl/ahb2ocp_ram_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ahb2ocp_ram_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb2ocp_ram_ctrl_pkg.sv
// Shared state encoding and port indices for the ahb2ocp RAM controller.
package ahb2ocp_ram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int P0 = 0;
    localparam int P1 = 1;

endpackage

// File: rtl/ahb2ocp_ram_rr_arb.sv
// Two-way round-robin arbiter: on a tie the port not granted most recently wins.
module ahb2ocp_ram_rr_arb
    import ahb2ocp_ram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic       last_q;
    logic       last_d;
    logic [1:0] gnt_d;

    always_comb begin
        gnt_d  = 2'b00;
        last_d = last_q;
        if (enable) begin
            if (req[P0] && req[P1]) begin
                if (last_q) begin
                    gnt_d[P0] = 1'b1;
                end else begin
                    gnt_d[P1] = 1'b1;
                end
            end else if (req[P0]) begin
                gnt_d[P0] = 1'b1;
            end else if (req[P1]) begin
                gnt_d[P1] = 1'b1;
            end
            if (gnt_d[P1]) begin
                last_d = 1'b1;
            end else if (gnt_d[P0]) begin
                last_d = 1'b0;
            end
        end
    end

    assign gnt = gnt_d;

    // Pointer resets to port 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ahb2ocp_ram_ctrl.sv
// Sequencer and two-port arbiter in front of the single-port ahb2ocp_ram:
// zero-fills the array after reset, then shares it between the AHB and OCP sides.
module ahb2ocp_ram_ctrl
    import ahb2ocp_ram_ctrl_pkg::*;
#(
    parameter int WORDS     = 8,
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 we0,
    input  logic [ADDR_SIZE-1:0] addr0,
    input  logic [DATA_SIZE-1:0] wdata0,
    input  logic [DATA_SIZE-1:0] be0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic [ADDR_SIZE-1:0] addr1,
    input  logic [DATA_SIZE-1:0] wdata1,
    input  logic [DATA_SIZE-1:0] be1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [DATA_SIZE-1:0] rdata0,
    output logic [DATA_SIZE-1:0] rdata1,
    output logic                 err0,
    output logic                 err1,
    output logic                 init_done,
    output logic                 ram_cs,
    output logic                 ram_rd_e,
    output logic                 ram_wr_e,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [DATA_SIZE-1:0] ram_wdata,
    output logic [DATA_SIZE-1:0] ram_be,
    input  logic [DATA_SIZE-1:0] ram_rdata
);

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(WORDS - 1);

    function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
        return int'(a) < WORDS;
    endfunction

    state_t                 state_q;
    state_t                 state_d;
    logic [ADDR_SIZE-1:0]   clr_cnt_q;
    logic [ADDR_SIZE-1:0]   clr_cnt_d;
    logic                   init_done_q;
    logic                   init_done_d;
    logic [1:0]             rvalid_q;
    logic [1:0]             rvalid_d;
    logic [1:0]             err_q;
    logic [1:0]             err_d;

    logic                   arb_en;
    logic [1:0]             arb_gnt;
    logic                   oor0;
    logic                   oor1;
    logic                   sel_p1;
    logic                   cmd_we;
    logic                   cmd_oor;
    logic [ADDR_SIZE-1:0]   cmd_addr;
    logic [DATA_SIZE-1:0]   cmd_wdata;
    logic [DATA_SIZE-1:0]   cmd_be;

    assign arb_en = (state_q == ST_RUN);

    ahb2ocp_ram_rr_arb u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1, req0}),
        .enable (arb_en),
        .gnt    (arb_gnt)
    );

    assign oor0      = !in_range(addr0);
    assign oor1      = !in_range(addr1);
    assign sel_p1    = arb_gnt[P1];
    assign cmd_we    = sel_p1 ? we1    : we0;
    assign cmd_oor   = sel_p1 ? oor1   : oor0;
    assign cmd_addr  = sel_p1 ? addr1  : addr0;
    assign cmd_wdata = sel_p1 ? wdata1 : wdata0;
    assign cmd_be    = sel_p1 ? be1    : be0;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ram_cs    = 1'b0;
        ram_rd_e  = 1'b0;
        ram_wr_e  = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_be    = '0;
        case (state_q)
            ST_WAIT: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
            ST_CLEAR: begin
                ram_cs   = 1'b1;
                ram_wr_e = 1'b1;
                ram_addr = clr_cnt_q;
                ram_be   = '1;
                // Equality compare keeps the exit correct when WORDS fills the address space.
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_SIZE'(1);
                end
            end
            ST_RUN: begin
                if (|arb_gnt) begin
                    ram_addr  = cmd_addr;
                    ram_wdata = cmd_wdata;
                    ram_be    = cmd_be;
                    if (!cmd_oor) begin
                        ram_cs   = 1'b1;
                        ram_wr_e = cmd_we;
                        ram_rd_e = !cmd_we;
                    end
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    always_comb begin
        init_done_d  = (state_d == ST_RUN);
        rvalid_d     = 2'b00;
        err_d        = 2'b00;
        rvalid_d[P0] = arb_gnt[P0] && !we0;
        rvalid_d[P1] = arb_gnt[P1] && !we1;
        err_d[P0]    = arb_gnt[P0] && oor0;
        err_d[P1]    = arb_gnt[P1] && oor1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            rvalid_q    <= 2'b00;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
        end
    end

    assign gnt0      = arb_gnt[P0];
    assign gnt1      = arb_gnt[P1];
    assign init_done = init_done_q;
    assign rvalid0   = rvalid_q[P0];
    assign rvalid1   = rvalid_q[P1];
    assign err0      = err_q[P0];
    assign err1      = err_q[P1];
    // An out-of-range read never reached the RAM, so its data is forced to zero.
    assign rdata0    = err_q[P0] ? '0 : ram_rdata;
    assign rdata1    = err_q[P1] ? '0 : ram_rdata;

endmodule

// File: tb/tb_ahb2ocp_ram_ctrl.sv
// Randomised bench for ahb2ocp_ram_ctrl with a behavioural RAM and a reference memory model.
module tb_ahb2ocp_ram_ctrl;

    localparam int WORDS = 8;
    localparam int DW    = 32;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rq [2];
    logic          wq [2];
    logic [AW-1:0] aq [2];
    logic [DW-1:0] dq [2];
    logic [DW-1:0] bq [2];

    logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1, init_done;
    logic [DW-1:0] rdata0, rdata1;
    logic          ram_cs, ram_rd_e, ram_wr_e;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_be;
    logic [DW-1:0] ram_rdata = 32'h0BAD_0BAD;

    logic          gv [2];
    logic          rv [2];
    logic          ev [2];
    logic [DW-1:0] dv [2];

    assign gv[0] = gnt0;    assign gv[1] = gnt1;
    assign rv[0] = rvalid0; assign rv[1] = rvalid1;
    assign ev[0] = err0;    assign ev[1] = err1;
    assign dv[0] = rdata0;  assign dv[1] = rdata1;

    always #5 clk = ~clk;

    ahb2ocp_ram_ctrl #(.WORDS(WORDS), .DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(rq[0]), .we0(wq[0]), .addr0(aq[0]), .wdata0(dq[0]), .be0(bq[0]),
        .req1(rq[1]), .we1(wq[1]), .addr1(aq[1]), .wdata1(dq[1]), .be1(bq[1]),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .init_done(init_done), .ram_cs(ram_cs), .ram_rd_e(ram_rd_e), .ram_wr_e(ram_wr_e),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata)
    );

    // Single-port RAM with a registered read port that only updates on reads.
    logic [DW-1:0] ram_mem [16] = '{default: 32'hDEAD_BEEF};
    always @(posedge clk) begin
        if (ram_cs && ram_rd_e) ram_rdata <= ram_mem[ram_addr];
        if (ram_cs && ram_wr_e) ram_mem[ram_addr] <= (ram_mem[ram_addr] & ~ram_be) | (ram_wdata & ram_be);
    end

    int            checks = 0;
    int            errors = 0;
    int            k;
    int            last;
    logic [DW-1:0] ref_mem [WORDS];
    logic          g_last [2];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input int p, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] b);
        rq[p] = 1'b1; wq[p] = w; aq[p] = a; dq[p] = d; bq[p] = b;
    endtask

    // One clock cycle: entered just after a falling edge with inputs already driven.
    task automatic tick();
        logic          eg [2];
        logic          nv [2];
        logic          ne [2];
        logic [DW-1:0] nd [2];
        bit            oor;
        int            idx;
        for (int p = 0; p < 2; p++) begin eg[p] = 0; nv[p] = 0; ne[p] = 0; nd[p] = '0; end
        #1;
        if (k >= WORDS + 1) begin
            if (rq[0] && rq[1]) eg[1 - last] = 1'b1;
            else if (rq[0]) eg[0] = 1'b1;
            else if (rq[1]) eg[1] = 1'b1;
        end
        chk("gnt0", gnt0, eg[0]);
        chk("gnt1", gnt1, eg[1]);
        if (k >= 1 && k <= WORDS) begin
            chk("fill_strobes", {ram_cs, ram_wr_e, ram_rd_e}, 3'b110);
            chk("fill_addr", ram_addr, AW'(k - 1));
            chk("fill_wdata", ram_wdata, '0);
            chk("fill_be", ram_be, '1);
        end else if (!eg[0] && !eg[1]) begin
            chk("idle_strobes", {ram_cs, ram_wr_e, ram_rd_e}, 3'b000);
        end
        for (int p = 0; p < 2; p++) begin
            if (eg[p]) begin
                idx = int'(aq[p]);
                oor = idx >= WORDS;
                chk("ram_cs", ram_cs, !oor);
                if (!oor) begin
                    chk("ram_dir", {ram_wr_e, ram_rd_e}, {wq[p], !wq[p]});
                    chk("ram_addr", ram_addr, aq[p]);
                    if (wq[p]) begin
                        chk("ram_wdata", ram_wdata, dq[p]);
                        chk("ram_be", ram_be, bq[p]);
                        ref_mem[idx] = (ref_mem[idx] & ~bq[p]) | (dq[p] & bq[p]);
                    end
                end
                if (!wq[p]) begin
                    nv[p] = 1'b1;
                    nd[p] = oor ? '0 : ref_mem[idx];
                end
                ne[p] = oor;
                last  = p;
            end
        end
        @(posedge clk);
        k++;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            chk(p == 0 ? "rvalid0" : "rvalid1", rv[p], nv[p]);
            chk(p == 0 ? "err0" : "err1", ev[p], ne[p]);
            if (nv[p]) chk(p == 0 ? "rdata0" : "rdata1", dv[p], nd[p]);
            if (eg[p]) rq[p] = 1'b0;
            g_last[p] = eg[p];
        end
        chk("init_done", init_done, k >= WORDS + 1);
    endtask

    task automatic tick_until(input int p);
        bit got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            got = g_last[p];
        end
        if (!got) chk("grant_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_rvalid", {rvalid0, rvalid1}, 2'b00);
        chk("rst_err", {err0, err1}, 2'b00);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_gnt", {gnt0, gnt1}, 2'b00);
        chk("rst_strobes", {ram_cs, ram_wr_e, ram_rd_e}, 3'b000);
        k    = 0;
        last = 1;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic read_all(input int p);
        for (int i = 0; i < WORDS; i++) begin
            issue(p, 1'b0, AW'(i), '0, '0);
            tick_until(p);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < 2; p++) begin
            rq[p] = 0; wq[p] = 0; aq[p] = '0; dq[p] = '0; bq[p] = '0;
            g_last[p] = 0;
        end
        rst_n = 1'b0;
        do_reset();

        // Fill, then every word reads back as zero.
        for (int i = 0; i < WORDS + 1; i++) tick();
        read_all(1);

        // Partial write then read-back.
        issue(0, 1'b1, 4'd3, 32'hA5A5_A5A5, 32'h0000_FFFF);
        tick_until(0);
        issue(0, 1'b0, 4'd3, '0, '0);
        tick_until(0);

        // Contention: both ports read continuously for six cycles.
        issue(0, 1'b0, 4'd3, '0, '0);
        issue(1, 1'b0, 4'd0, '0, '0);
        for (int i = 0; i < 6; i++) begin
            tick();
            for (int p = 0; p < 2; p++)
                if (g_last[p]) issue(p, 1'b0, AW'($urandom_range(0, WORDS - 1)), '0, '0);
        end
        rq[0] = 0; rq[1] = 0;

        // Out-of-range read and write leave the array untouched.
        issue(1, 1'b0, 4'd9, '0, '0);
        tick_until(1);
        issue(0, 1'b1, 4'd12, 32'hFFFF_FFFF, '1);
        tick_until(0);
        read_all(0);

        // Read followed immediately by a write to the same word.
        issue(0, 1'b1, 4'd2, 32'h1111_1111, '1);
        tick_until(0);
        issue(0, 1'b0, 4'd2, '0, '0);
        tick_until(0);
        issue(0, 1'b1, 4'd2, 32'h2222_3333, '1);
        tick();
        issue(1, 1'b0, 4'd2, '0, '0);
        tick_until(1);

        // Reset in the middle of the fill, after address 4 has been written.
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        do_reset();
        for (int i = 0; i < WORDS + 1; i++) tick();

        // Reset with an in-range read and then an out-of-range read outstanding.
        issue(0, 1'b1, 4'd5, 32'h1234_5678, '1);
        tick_until(0);
        issue(0, 1'b0, 4'd5, '0, '0);
        tick_until(0);
        issue(1, 1'b0, 4'd1, '0, '0);
        do_reset();
        tick_until(1);
        issue(1, 1'b0, 4'd10, '0, '0);
        tick_until(1);
        do_reset();
        for (int i = 0; i < WORDS + 1; i++) tick();
        read_all(0);

        // Random traffic from both ports.
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rq[p] && $urandom_range(0, 2) == 0)
                    issue(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 10)), $urandom,
                          ($urandom_range(0, 1) != 0) ? '1 : DW'($urandom));
            end
            tick();
        end
        for (int i = 0; i < 10 && (rq[0] || rq[1]); i++) tick();
        if (rq[0] || rq[1]) chk("drain_timeout", 0, 1);
        read_all(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
